game_level_tracker: RTL and testbench



---
 rtl/tetris_stats_pkg.sv | 40 ++++
 rtl/game_level_tracker_if.sv | 12 +
 rtl/score_bcd_add.sv | 32 +++
 rtl/game_level_tracker.sv | 136 +++++++++++++
 tb/tb_game_level_tracker.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_stats_pkg.sv
// rtl/tetris_stats_pkg.sv - shared state encoding and line-clear points tables for the level tracker
package tetris_stats_pkg;

  typedef enum logic {IDLE = 1'b0, ADD = 1'b1} state_t;

  localparam int CLR_LINES_W = 3;

  localparam logic [23:0] PTS_BIN_1 = 24'd40;
  localparam logic [23:0] PTS_BIN_2 = 24'd100;
  localparam logic [23:0] PTS_BIN_3 = 24'd300;
  localparam logic [23:0] PTS_BIN_4 = 24'd1200;

  localparam logic [23:0] PTS_BCD_1 = 24'h000040;
  localparam logic [23:0] PTS_BCD_2 = 24'h000100;
  localparam logic [23:0] PTS_BCD_3 = 24'h000300;
  localparam logic [23:0] PTS_BCD_4 = 24'h001200;

  localparam logic [23:0] BCD_MAX = 24'h999999;

  function automatic logic [23:0] points_bin(input logic [CLR_LINES_W-1:0] n);
    case (n)
      3'd1:    return PTS_BIN_1;
      3'd2:    return PTS_BIN_2;
      3'd3:    return PTS_BIN_3;
      3'd4:    return PTS_BIN_4;
      default: return 24'd0;
    endcase
  endfunction

  function automatic logic [23:0] points_bcd(input logic [CLR_LINES_W-1:0] n);
    case (n)
      3'd1:    return PTS_BCD_1;
      3'd2:    return PTS_BCD_2;
      3'd3:    return PTS_BCD_3;
      3'd4:    return PTS_BCD_4;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/game_level_tracker_if.sv
// rtl/game_level_tracker_if.sv - line-clear report handshake between playfield (master) and tracker (slave)
interface game_level_tracker_if;
  import tetris_stats_pkg::*;

  logic                   clr_valid_i;
  logic [CLR_LINES_W-1:0] clr_lines_i;
  logic                   ready_o;

  modport master (output clr_valid_i, output clr_lines_i, input ready_o);
  modport slave  (input clr_valid_i, input clr_lines_i, output ready_o);

endinterface

// File: rtl/score_bcd_add.sv
// rtl/score_bcd_add.sv - six-digit packed BCD adder, saturating at 999999
module score_bcd_add
  import tetris_stats_pkg::*;
(
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [23:0] sum
);

  logic [23:0] raw;
  logic        carry;
  logic [4:0]  digit;

  always_comb begin
    raw   = '0;
    carry = 1'b0;
    digit = '0;
    for (int i = 0; i < 6; i++) begin
      digit = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, carry};
      if (digit > 5'd9) begin
        raw[4*i +: 4] = 4'(digit - 5'd10);
        carry         = 1'b1;
      end else begin
        raw[4*i +: 4] = digit[3:0];
        carry         = 1'b0;
      end
    end
    // A carry out of the top digit means the total passed 999999.
    sum = carry ? BCD_MAX : raw;
  end

endmodule

// File: rtl/game_level_tracker.sv
// rtl/game_level_tracker.sv - lines/level/score tracker feeding the fall-rate generator
// TETRIS_SCORE_BCD_EN selects a 6-digit packed BCD score instead of a binary one.
module game_level_tracker
  import tetris_stats_pkg::*;
#(
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 15,
  parameter int LEVEL_W         = 5,
  parameter int LINES_W         = 16,
  parameter int SCORE_W         = 24
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 new_game_i,
  game_level_tracker_if.slave  clr,
  output logic [LINES_W-1:0]   lines_o,
  output logic [LEVEL_W-1:0]   level_o,
`ifdef TETRIS_SCORE_BCD_EN
  output logic [23:0]          score_o,
`else
  output logic [SCORE_W-1:0]   score_o,
`endif
  output logic                 level_changed_o,
  output logic                 score_upd_o
);

`ifdef TETRIS_SCORE_BCD_EN
  localparam int SC_W = 24;
`else
  localparam int SC_W = SCORE_W;
`endif
  // Holds the worst-case in-level count (LINES_PER_LEVEL-1) plus a 4-line clear.
  localparam int IN_W = $clog2(LINES_PER_LEVEL + 5);

  if (LINES_PER_LEVEL < 4) begin : g_lpl_chk
    $error("LINES_PER_LEVEL must be at least 4");
  end
  if (MAX_LEVEL >= (1 << LEVEL_W)) begin : g_lvl_chk
    $error("LEVEL_W too narrow for MAX_LEVEL");
  end
  if (SCORE_W < 11) begin : g_score_chk
    $error("SCORE_W too narrow for the points table");
  end

  state_t             state;
  logic [23:0]        base;
  logic [LEVEL_W-1:0] mult_cnt;
  logic [IN_W-1:0]    in_cnt;
  logic [IN_W-1:0]    in_sum;
  logic [LINES_W:0]   lines_sum;
  logic [SC_W-1:0]    score_next;
  logic [23:0]        pts;
  logic               lines_ok;
  logic               accept;

  assign clr.ready_o = (state == IDLE) && !new_game_i;
  // Out-of-range counts complete the handshake but are treated like an empty clear.
  assign lines_ok    = (clr.clr_lines_i != '0) && (clr.clr_lines_i <= 3'd4);
  assign accept      = clr.clr_valid_i && clr.ready_o && lines_ok;
  assign in_sum      = in_cnt + IN_W'(clr.clr_lines_i);
  assign lines_sum   = {1'b0, lines_o} + (LINES_W+1)'(clr.clr_lines_i);

`ifdef TETRIS_SCORE_BCD_EN
  assign pts = points_bcd(clr.clr_lines_i);

  score_bcd_add u_score_add (
    .a   (score_o),
    .b   (base),
    .sum (score_next)
  );
`else
  logic [SC_W:0] bin_sum;

  assign pts        = points_bin(clr.clr_lines_i);
  assign bin_sum    = {1'b0, score_o} + (SC_W+1)'(base);
  assign score_next = bin_sum[SC_W] ? '1 : bin_sum[SC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      base            <= '0;
      mult_cnt        <= '0;
      in_cnt          <= '0;
      lines_o         <= '0;
      level_o         <= '0;
      score_o         <= '0;
      level_changed_o <= 1'b0;
      score_upd_o     <= 1'b0;
    end else begin
      level_changed_o <= 1'b0;
      score_upd_o     <= 1'b0;
      if (new_game_i) begin
        state    <= IDLE;
        mult_cnt <= '0;
        in_cnt   <= '0;
        lines_o  <= '0;
        level_o  <= '0;
        score_o  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              base     <= pts;
              mult_cnt <= level_o;
              lines_o  <= lines_sum[LINES_W] ? '1 : lines_sum[LINES_W-1:0];
              if (in_sum >= IN_W'(LINES_PER_LEVEL)) begin
                in_cnt <= in_sum - IN_W'(LINES_PER_LEVEL);
                if (level_o < LEVEL_W'(MAX_LEVEL)) begin
                  level_o         <= level_o + 1'b1;
                  level_changed_o <= 1'b1;
                end
              end else begin
                in_cnt <= in_sum;
              end
              state <= ADD;
            end
          end
          // One base addition per cycle multiplies by (old level + 1).
          ADD: begin
            score_o <= score_next;
            if (mult_cnt == '0) begin
              score_upd_o <= 1'b1;
              state       <= IDLE;
            end else begin
              mult_cnt <= mult_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_level_tracker.sv
// tb/tb_game_level_tracker.sv - directed self-checking bench for game_level_tracker
module tb_game_level_tracker;
  import tetris_stats_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_game = 1'b0;
  logic [15:0] lines;
  logic [4:0]  level;
  logic [23:0] score;
  logic        level_changed;
  logic        score_upd;

  int n_vec = 0;
  int n_miss = 0;

  int     e_lines, e_level, e_in, e_lc;
  longint e_score;

`ifdef TETRIS_SCORE_BCD_EN
  localparam longint SMAX = 999999;
`else
  localparam longint SMAX = 64'd16777215;
`endif

  game_level_tracker_if clr_if ();

  game_level_tracker dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .new_game_i      (new_game),
    .clr             (clr_if),
    .lines_o         (lines),
    .level_o         (level),
    .score_o         (score),
    .level_changed_o (level_changed),
    .score_upd_o     (score_upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] enc(input longint v);
    logic [23:0] r;
    longint t;
    r = '0;
    t = v;
`ifdef TETRIS_SCORE_BCD_EN
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`else
    r = 24'(t);
`endif
    return r;
  endfunction

  function automatic int pts(input int n);
    case (n)
      1: return 40;
      2: return 100;
      3: return 300;
      4: return 1200;
      default: return 0;
    endcase
  endfunction

  task automatic model_clear();
    e_lines = 0; e_level = 0; e_in = 0; e_score = 0;
  endtask

  task automatic model(input int n, output int old);
    old = e_level;
    if (n >= 1 && n <= 4) begin
      e_score = e_score + longint'(pts(n)) * (old + 1);
      if (e_score > SMAX) e_score = SMAX;
      e_lines = e_lines + n;
      e_in    = e_in + n;
      if (e_in >= 10) begin
        e_in = e_in - 10;
        if (e_level < 15) begin
          e_level++;
          e_lc++;
        end
      end
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, " lines"}, lines, e_lines);
    check({tag, " level"}, level, e_level);
    check({tag, " score"}, score, enc(e_score));
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!clr_if.ready_o && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (k >= 64) check("ready timeout", 0, 1);
  endtask

  // Called at a negedge with ready high; returns at a negedge with ready high.
  task automatic report(input int n);
    int  old, busy, lc_seen, upd_seen, lc_before, exp_busy;
    bit  scoring;
    scoring   = (n >= 1 && n <= 4);
    lc_before = e_lc;
    clr_if.clr_valid_i = 1'b1;
    clr_if.clr_lines_i = 3'(n);
    wait_ready();
    @(posedge clk); #1;
    clr_if.clr_valid_i = 1'b0;
    model(n, old);
    exp_busy = scoring ? old + 1 : 0;
    @(negedge clk);
    busy = 0; upd_seen = 0;
    lc_seen = int'(level_changed);
    while (!clr_if.ready_o && busy < 64) begin
      busy++;
      @(negedge clk);
      lc_seen  += int'(level_changed);
      upd_seen += int'(score_upd);
    end
    check("busy cycles", busy, exp_busy);
    check("score_upd at idle", score_upd, scoring);
    @(negedge clk);
    lc_seen  += int'(level_changed);
    upd_seen += int'(score_upd);
    check("level_changed count", lc_seen, e_lc - lc_before);
    check("score_upd count", upd_seen, scoring ? 1 : 0);
    check_stats("report");
  endtask

  initial begin
    int old, busy, cnt, iter;
    longint s_before;
    int l_before;
    clr_if.clr_valid_i = 1'b0;
    clr_if.clr_lines_i = '0;
    e_lc = 0;
    model_clear();

    #1;
    check("reset lines", lines, 0);
    check("reset level", level, 0);
    check("reset score", score, 0);
    check("reset ready", clr_if.ready_o, 1);
    check("reset pulses", {level_changed, score_upd}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Nine singles at level 0, then a double crossing into level 1.
    for (int i = 0; i < 9; i++) report(1);
    check("nine singles score", score, enc(360));
    check("nine singles lines", lines, 9);
    check("nine singles pulses", e_lc, 0);
    report(2);
    check("level1 lines", lines, 11);
    check("level1 level", level, 1);
    check("level1 score", score, enc(460));

    // Tetris at level 3 with the next report held while busy.
    while (e_level < 3) report(4);
    s_before = e_score;
    clr_if.clr_valid_i = 1'b1;
    clr_if.clr_lines_i = 3'd4;
    @(posedge clk); #1;
    model(4, old);
    clr_if.clr_lines_i = 3'd1;
    busy = 0;
    @(negedge clk);
    while (!clr_if.ready_o && busy < 64) begin
      busy++;
      @(negedge clk);
    end
    check("held busy", busy, 4);
    check("held score_upd", score_upd, 1);
    check("held plus4800", score, enc(s_before + 4800));
    @(posedge clk); #1;
    clr_if.clr_valid_i = 1'b0;
    model(1, old);
    @(negedge clk);
    check("held accepted", clr_if.ready_o, 0);
    wait_ready();
    @(negedge clk);
    check_stats("held next");

    // Saturate the level, then keep clearing lines.
    while (e_level < 15) report(4);
    l_before = e_lines;
    cnt = e_lc;
    report(4); report(4); report(2);
    check("max level held", level, 15);
    check("max level lines", lines, l_before + 10);
    check("max level no pulse", e_lc, cnt);

    // New game, climb to level 5, abort during the second ADD cycle.
    @(negedge clk); new_game = 1'b1;
    @(posedge clk); #1; new_game = 1'b0;
    model_clear();
    @(negedge clk);
    check_stats("new game");
    while (e_level < 5) report(4);
    clr_if.clr_valid_i = 1'b1;
    clr_if.clr_lines_i = 3'd3;
    @(posedge clk); #1;
    clr_if.clr_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    new_game = 1'b1;
    clr_if.clr_valid_i = 1'b1;
    clr_if.clr_lines_i = 3'd1;
    #1;
    check("abort ready low", clr_if.ready_o, 0);
    @(posedge clk); #1;
    new_game = 1'b0;
    clr_if.clr_valid_i = 1'b0;
    model_clear();
    @(negedge clk);
    check_stats("abort");
    check("abort ready", clr_if.ready_o, 1);
    check("abort level_changed", level_changed, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cnt += int'(score_upd);
      @(negedge clk);
    end
    check("abort no score_upd", cnt, 0);

    // New game in IDLE wins over a simultaneous report.
    new_game = 1'b1;
    clr_if.clr_valid_i = 1'b1;
    clr_if.clr_lines_i = 3'd4;
    #1;
    check("ng idle ready low", clr_if.ready_o, 0);
    @(posedge clk); #1;
    new_game = 1'b0;
    clr_if.clr_valid_i = 1'b0;
    @(negedge clk);
    check("ng idle lines", lines, 0);
    check("ng idle ready", clr_if.ready_o, 1);

    // Asynchronous reset between edges.
    report(3);
    #2 rst_n = 1'b0;
    #1;
    check("async lines", lines, 0);
    check("async score", score, 0);
    check("async ready", clr_if.ready_o, 1);
    @(negedge clk); rst_n = 1'b1;
    model_clear();
    @(negedge clk);

    // Empty and out-of-range reports are swallowed.
    report(1);
    report(0);
    report(6);
    check("ignored lines", lines, 1);
    check("ignored ready", clr_if.ready_o, 1);

    // Drive the score into saturation.
    iter = 0;
    while (e_score < SMAX && iter < 1200) begin
      report(4);
      iter++;
    end
    check("score saturated", score, enc(SMAX));
    report(4);
    check("score stays saturated", score, enc(SMAX));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
